// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: redirect input, sram-like instruction port and the
// valid/ready hand-off towards ID. The fetch unit uses "master", its
// environment (memory, ID, exception logic) uses "slave".
interface if_fetch_queue_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic [7:0]  if_except_o;

  modport master (
    input  redirect_i, redirect_pc_i, inst_addr_ok_i, inst_data_ok_i,
           inst_rdata_i, id_ready_i,
    output inst_req_o, inst_addr_o, if_valid_o, if_pc_o, if_instr_o,
           if_except_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, inst_addr_ok_i, inst_data_ok_i,
           inst_rdata_i, id_ready_i,
    input  inst_req_o, inst_addr_o, if_valid_o, if_pc_o, if_instr_o,
           if_except_o
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Decoupled instruction prefetcher: pipelined requests on an sram-like port,
// in-order instruction queue towards ID, redirect flush with stale-response
// discard, and AdEL entries for misaligned fetch addresses.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'hBFC0_0000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  if_fetch_queue_if.master bus
);
  localparam int QW  = $clog2(QUEUE_DEPTH);
  localparam int QCW = $clog2(QUEUE_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW  = QCW + 1;
  localparam int FW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [7:0] EXC_ADEL = 8'h80;

  logic [31:0]    fetch_pc;
  logic           halted;
  logic [OCW-1:0] inflight_cnt;
  logic [OCW-1:0] stale_cnt;
  logic [OCW-1:0] inflight_live;
  logic [QCW-1:0] queue_cnt;
  logic [QW-1:0]  q_head;
  logic [QW-1:0]  q_tail;
  logic [FW-1:0]  fl_head;
  logic [FW-1:0]  fl_tail;

  logic [31:0] q_pc    [QUEUE_DEPTH];
  logic [31:0] q_instr [QUEUE_DEPTH];
  logic [7:0]  q_exc   [QUEUE_DEPTH];
  logic [31:0] fl_pc   [MAX_OUTSTANDING];

  logic [CW-1:0] occupancy;
  logic          credit_ok;
  logic          misaligned;
  logic          below_max;
  logic          req;
  logic          accept;
  logic          resp;
  logic          resp_live;
  logic          exc_push;
  logic          q_push;
  logic          q_pop;
  logic          q_valid;
  logic [31:0]   push_pc;
  logic [31:0]   push_instr;
  logic [7:0]    push_exc;

  // In-flight PC FIFO pointer advance; depth need not be a power of two.
  function automatic logic [FW-1:0] fl_next(input logic [FW-1:0] p);
    if (p == FW'(MAX_OUTSTANDING - 1)) return '0;
    return p + FW'(1);
  endfunction

  // Credit counts queued entries plus live (non-stale) in-flight requests, so
  // every live response is guaranteed a queue slot when it arrives.
  assign inflight_live = inflight_cnt - stale_cnt;
  assign occupancy     = CW'(queue_cnt) + CW'(inflight_live);
  assign credit_ok     = occupancy < CW'(QUEUE_DEPTH);
  assign misaligned    = fetch_pc[1:0] != 2'b00;
  assign below_max     = inflight_cnt < OCW'(MAX_OUTSTANDING);

  assign req       = !rst_i && !halted && !bus.redirect_i && !misaligned
                     && credit_ok && below_max;
  assign accept    = req && bus.inst_addr_ok_i;
  // A response with nothing in flight is ignored so counters cannot wrap.
  assign resp      = bus.inst_data_ok_i && (inflight_cnt != '0);
  assign resp_live = resp && (stale_cnt == '0);
  assign exc_push  = !halted && credit_ok && !bus.redirect_i && misaligned;

  // Live responses and AdEL entries never coincide: a misaligned PC only
  // follows a redirect, which marks everything in flight as stale.
  assign q_push     = !bus.redirect_i && (resp_live || exc_push);
  assign q_valid    = queue_cnt != '0;
  assign q_pop      = !bus.redirect_i && q_valid && bus.id_ready_i;
  assign push_pc    = resp_live ? fl_pc[fl_head]   : fetch_pc;
  assign push_instr = resp_live ? bus.inst_rdata_i : 32'h0;
  assign push_exc   = resp_live ? 8'h00            : EXC_ADEL;

  assign bus.inst_req_o  = req;
  assign bus.inst_addr_o = fetch_pc;
  assign bus.if_valid_o  = q_valid;
  assign bus.if_pc_o     = q_valid ? q_pc[q_head]    : 32'h0;
  assign bus.if_instr_o  = q_valid ? q_instr[q_head] : 32'h0;
  assign bus.if_except_o = q_valid ? q_exc[q_head]   : 8'h00;

  // Fetch PC and halt flag: redirect restarts fetch, accept advances it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
    end else if (bus.redirect_i) begin
      fetch_pc <= bus.redirect_pc_i;
      halted   <= 1'b0;
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (exc_push) halted <= 1'b1;
    end
  end

  // In-flight bookkeeping: outstanding count, stale count and FIFO pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_cnt <= '0;
      stale_cnt    <= '0;
      fl_head      <= '0;
      fl_tail      <= '0;
    end else begin
      if (accept && !resp) inflight_cnt <= inflight_cnt + OCW'(1);
      else if (!accept && resp) inflight_cnt <= inflight_cnt - OCW'(1);
      if (bus.redirect_i) stale_cnt <= inflight_cnt - OCW'(resp);
      else if (resp && stale_cnt != '0) stale_cnt <= stale_cnt - OCW'(1);
      if (accept) fl_tail <= fl_next(fl_tail);
      if (resp) fl_head <= fl_next(fl_head);
    end
  end

  // Instruction queue control; a redirect empties it outright.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      queue_cnt <= '0;
      q_head    <= '0;
      q_tail    <= '0;
    end else if (bus.redirect_i) begin
      queue_cnt <= '0;
      q_head    <= '0;
      q_tail    <= '0;
    end else begin
      if (q_push && !q_pop) queue_cnt <= queue_cnt + QCW'(1);
      else if (!q_push && q_pop) queue_cnt <= queue_cnt - QCW'(1);
      if (q_push) q_tail <= q_tail + QW'(1);
      if (q_pop) q_head <= q_head + QW'(1);
    end
  end

  // Queue and in-flight PC storage; contents are qualified by the counters.
  always_ff @(posedge clk_i) begin
    if (q_push) begin
      q_pc[q_tail]    <= push_pc;
      q_instr[q_tail] <= push_instr;
      q_exc[q_tail]   <= push_exc;
    end
    if (accept) fl_pc[fl_tail] <= fetch_pc;
  end

  // Responses must always match an outstanding request.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.inst_data_ok_i && inflight_cnt == '0));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a one-cycle-latency memory responder
// and an in-order scoreboard of expected ID entries.
module tb_if_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  exc;
  } entry_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  if_fetch_queue_if bus();

  if_fetch_queue #(
    .RESET_PC(RESET_PC),
    .QUEUE_DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  int          checks;
  int          failures;
  entry_t      sb[$];
  logic [31:0] pend_addr[$];
  bit          pend_live[$];
  logic [31:0] popped[$];
  logic [31:0] acc_log[$];
  logic [31:0] model_pc;
  bit          halted_m;
  bit          resp_en;
  int          accepts;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input int idx, input logic [31:0] exp);
    if (popped.size() > idx) chk(tag, 72'(popped[idx]), 72'(exp));
    else chk({tag, "_count"}, 72'(popped.size()), 72'(idx + 1));
  endtask

  task automatic model_reset();
    sb.delete();
    pend_addr.delete();
    pend_live.delete();
    model_pc = RESET_PC;
    halted_m = 0;
  endtask

  task automatic drive_resp();
    if (resp_en && pend_addr.size() != 0) begin
      bus.inst_data_ok_i = 1'b1;
      bus.inst_rdata_i   = word_of(pend_addr[0]);
    end else begin
      bus.inst_data_ok_i = 1'b0;
      bus.inst_rdata_i   = 32'h0;
    end
  endtask

  // One clock: check and update the model at the negedge, then drive the
  // responder for the next cycle just after the posedge.
  task automatic cycle();
    logic [31:0] a;
    bit          l;
    @(negedge clk_i);
    if (!rst_i) begin
      chk("if_valid", 72'(bus.if_valid_o), 72'(sb.size() != 0));
      if (bus.if_valid_o && sb.size() != 0) begin
        chk("head", {bus.if_pc_o, bus.if_instr_o, bus.if_except_o}, sb[0]);
        if (bus.id_ready_i && !bus.redirect_i) begin
          popped.push_back(sb[0].pc);
          void'(sb.pop_front());
        end
      end
      if (bus.inst_req_o) chk("req_addr", 72'(bus.inst_addr_o), 72'(model_pc));
      if (halted_m || model_pc[1:0] != 2'b00 || bus.redirect_i)
        chk("req_blocked", 72'(bus.inst_req_o), 72'(0));
      if (bus.redirect_i) begin
        sb.delete();
        if (bus.inst_data_ok_i && pend_addr.size() != 0) begin
          void'(pend_addr.pop_front());
          void'(pend_live.pop_front());
        end
        foreach (pend_live[i]) pend_live[i] = 0;
        model_pc = bus.redirect_pc_i;
        halted_m = 0;
      end else begin
        if (!halted_m && model_pc[1:0] != 2'b00) begin
          sb.push_back({model_pc, 32'h0, 8'h80});
          halted_m = 1;
        end
        if (bus.inst_data_ok_i && pend_addr.size() != 0) begin
          a = pend_addr.pop_front();
          l = pend_live.pop_front();
          if (l) sb.push_back({a, word_of(a), 8'h00});
        end
        if (bus.inst_req_o && bus.inst_addr_ok_i) begin
          pend_addr.push_back(model_pc);
          pend_live.push_back(1'b1);
          acc_log.push_back(model_pc);
          model_pc = model_pc + 32'd4;
          accepts++;
        end
      end
    end
    @(posedge clk_i);
    #1;
    if (!rst_i) drive_resp();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    bus.inst_data_ok_i = 1'b0;
    bus.redirect_i     = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resp_en  = 1;
    accepts  = 0;
    bus.redirect_i     = 1'b0;
    bus.redirect_pc_i  = 32'h0;
    bus.inst_addr_ok_i = 1'b1;
    bus.inst_data_ok_i = 1'b0;
    bus.inst_rdata_i   = 32'h0;
    bus.id_ready_i     = 1'b1;
    model_reset();

    // Reset state
    #2;
    chk("rst_req", 72'(bus.inst_req_o), 72'(0));
    chk("rst_valid", 72'(bus.if_valid_o), 72'(0));
    chk("rst_head", {bus.if_pc_o, bus.if_instr_o, bus.if_except_o}, 72'(0));
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // 1: streaming fetch, one entry per cycle in steady state
    popped.delete();
    repeat (4) cycle();
    repeat (6) begin
      cycle();
      chk("t1_steady_valid", 72'(bus.if_valid_o), 72'(1));
      chk("t1_steady_req", 72'(bus.inst_req_o), 72'(1));
    end
    chk_pop("t1_head0", 0, 32'hBFC0_0000);
    chk_pop("t1_head1", 1, 32'hBFC0_0004);
    chk_pop("t1_head2", 2, 32'hBFC0_0008);

    // 2: ID stalled -> credit limits to four requests
    bus.id_ready_i = 1'b0;
    do_reset();
    accepts = 0;
    acc_log.delete();
    repeat (10) cycle();
    chk("t2_accepts", 72'(accepts), 72'(4));
    chk("t2_req_off", 72'(bus.inst_req_o), 72'(0));
    chk("t2_full_valid", 72'(bus.if_valid_o), 72'(1));
    bus.id_ready_i = 1'b1;
    popped.delete();
    repeat (8) cycle();
    chk_pop("t2_head0", 0, 32'hBFC0_0000);
    chk_pop("t2_head1", 1, 32'hBFC0_0004);
    chk_pop("t2_head2", 2, 32'hBFC0_0008);
    chk_pop("t2_head3", 3, 32'hBFC0_000C);
    if (acc_log.size() > 4) chk("t2_resume", 72'(acc_log[4]), 72'(32'hBFC0_0010));
    else chk("t2_resume_count", 72'(acc_log.size()), 72'(5));

    // 3: redirect with two requests outstanding
    resp_en = 0;
    bus.inst_data_ok_i = 1'b0;
    repeat (3) cycle();
    chk("t3_max_outstanding", 72'(bus.inst_req_o), 72'(0));
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_1000;
    cycle();
    bus.redirect_i = 1'b0;
    chk("t3_empty_after", 72'(bus.if_valid_o), 72'(0));
    resp_en = 1;
    drive_resp();
    popped.delete();
    repeat (8) cycle();
    chk_pop("t3_first_head", 0, 32'h8000_1000);
    chk_pop("t3_second_head", 1, 32'h8000_1004);

    // 4: redirect coinciding with a response, two in flight
    resp_en = 0;
    bus.inst_data_ok_i = 1'b0;
    repeat (3) cycle();
    resp_en = 1;
    drive_resp();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_2000;
    cycle();
    bus.redirect_i = 1'b0;
    popped.delete();
    repeat (8) cycle();
    chk_pop("t4_first_head", 0, 32'h8000_2000);
    chk_pop("t4_second_head", 1, 32'h8000_2004);

    // 5: misaligned redirect -> AdEL entry, fetch halted until redirect
    bus.id_ready_i    = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_0002;
    cycle();
    bus.redirect_i = 1'b0;
    repeat (5) cycle();
    chk("t5_req_halted", 72'(bus.inst_req_o), 72'(0));
    chk("t5_exc_head", {bus.if_pc_o, bus.if_instr_o, bus.if_except_o},
        {32'h8000_0002, 32'h0, 8'h80});
    bus.id_ready_i    = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h8000_0100;
    cycle();
    bus.redirect_i = 1'b0;
    popped.delete();
    repeat (8) cycle();
    chk_pop("t5_restart_head", 0, 32'h8000_0100);

    // 6: asynchronous reset in the middle of a burst
    resp_en = 0;
    bus.inst_data_ok_i = 1'b0;
    repeat (2) cycle();
    rst_i = 1'b1;
    #1;
    chk("t6_valid_async", 72'(bus.if_valid_o), 72'(0));
    chk("t6_req_async", 72'(bus.inst_req_o), 72'(0));
    model_reset();
    resp_en = 1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("t6_req_after", 72'(bus.inst_req_o), 72'(1));
    chk("t6_addr_after", 72'(bus.inst_addr_o), 72'(RESET_PC));
    popped.delete();
    repeat (8) cycle();
    chk_pop("t6_first_head", 0, RESET_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
